// File: rtl/control_unit.sv
// Hardwired sequencer for the 16-bit teaching CPU: fetches a two-byte
// instruction into IR, then issues Moore control words for LDI/LDM/ST/ALU/BRA/BZ.
//
// state   | meaning
// INIT    | clear RF and ARF, then start fetching
// FETCH_H | read mem[PC] into IR[15:8], PC++
// FETCH_L | read mem[PC] into IR[7:0], PC++
// EXEC    | first execute cycle, decoded from opcode
// EXEC2   | memory access cycle for LDM / ST
module control_unit (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [15:0] IR_In,
  input  logic [3:0]  Flags,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FETCH_H = 3'd1,
    FETCH_L = 3'd2,
    EXEC    = 3'd3,
    EXEC2   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ALU = 4'h3;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_BZ  = 4'h5;

  localparam logic [1:0] FUN_INC   = 2'd1;
  localparam logic [1:0] FUN_LOAD  = 2'd2;
  localparam logic [1:0] FUN_CLEAR = 2'd3;

  state_t state, state_nxt;

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] rd_en_b;
  logic       zero_flag;
  logic       unused_bits;

  assign opcode      = IR_In[15:12];
  assign rd          = IR_In[11:10];
  assign rs          = IR_In[9:8];
  assign zero_flag   = Flags[3];
  // RD=0 is R1, which sits on RegSel bit 3
  assign rd_en_b     = ~(4'b1000 >> rd);
  assign unused_bits = ^{IR_In[3:0], Flags[2:0]};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    RF_OutASel  = 2'd0;
    RF_OutBSel  = 2'd0;
    RF_FunSel   = 2'd0;
    RF_RegSel   = 4'b1111;
    ALU_FunSel  = 4'd0;
    ARF_OutCSel = 2'd0;
    ARF_OutDSel = 2'd0;
    ARF_FunSel  = 2'd0;
    ARF_RegSel  = 3'b111;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'd0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'd0;
    MuxBSel     = 2'd0;
    MuxCSel     = 1'b0;
    Illegal     = 1'b0;

    case (state)
      INIT: begin
        RF_FunSel  = FUN_CLEAR;
        RF_RegSel  = 4'b0000;
        ARF_FunSel = FUN_CLEAR;
        ARF_RegSel = 3'b000;
        state_nxt  = FETCH_H;
      end

      FETCH_H, FETCH_L: begin
        Mem_CS      = 1'b0;
        ARF_OutDSel = 2'd0;
        IR_Enable   = 1'b1;
        IR_Funsel   = FUN_LOAD;
        IR_LH       = (state == FETCH_L);
        ARF_FunSel  = FUN_INC;
        ARF_RegSel  = 3'b011;
        state_nxt   = (state == FETCH_H) ? FETCH_L : EXEC;
      end

      EXEC: begin
        state_nxt = FETCH_H;
        case (opcode)
          OP_LDI: begin
            MuxASel   = 2'd0;
            RF_FunSel = FUN_LOAD;
            RF_RegSel = rd_en_b;
          end
          OP_LDM, OP_ST: begin
            MuxBSel    = 2'd1;
            ARF_FunSel = FUN_LOAD;
            ARF_RegSel = 3'b101;
            state_nxt  = EXEC2;
          end
          OP_ALU: begin
            RF_OutASel = rd;
            RF_OutBSel = rs;
            MuxCSel    = 1'b1;
            ALU_FunSel = IR_In[7:4];
            MuxASel    = 2'd3;
            RF_FunSel  = FUN_LOAD;
            RF_RegSel  = rd_en_b;
          end
          OP_BRA: begin
            MuxBSel    = 2'd1;
            ARF_FunSel = FUN_LOAD;
            ARF_RegSel = 3'b011;
          end
          OP_BZ: begin
            if (zero_flag) begin
              MuxBSel    = 2'd1;
              ARF_FunSel = FUN_LOAD;
              ARF_RegSel = 3'b011;
            end
          end
          default: Illegal = 1'b1;
        endcase
      end

      EXEC2: begin
        state_nxt = FETCH_H;
        if (opcode == OP_LDM) begin
          Mem_CS      = 1'b0;
          ARF_OutDSel = 2'd2;
          MuxASel     = 2'd1;
          RF_FunSel   = FUN_LOAD;
          RF_RegSel   = rd_en_b;
        end else if (opcode == OP_ST) begin
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b1;
          ARF_OutDSel = 2'd2;
          RF_OutASel  = rd;
          MuxCSel     = 1'b1;
          ALU_FunSel  = 4'd0;
        end
      end

      default: state_nxt = INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// instruction streams compared cycle by cycle against a per-instruction model.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] IR_In = 16'h0000;
  logic [3:0]  Flags = 4'h0;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] ra, rb, rf_fun;
    logic [3:0] rf_reg, alu_fun;
    logic [1:0] ac, ad, arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh, ir_en;
    logic [1:0] ir_fun;
    logic       wr, cs;
    logic [1:0] ma, mb;
    logic       mc, ill;
  } outs_t;

  outs_t dut_o;

  control_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR_In(IR_In), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .Illegal(Illegal)
  );

  assign dut_o = '{ra: RF_OutASel, rb: RF_OutBSel, rf_fun: RF_FunSel,
                   rf_reg: RF_RegSel, alu_fun: ALU_FunSel, ac: ARF_OutCSel,
                   ad: ARF_OutDSel, arf_fun: ARF_FunSel, arf_reg: ARF_RegSel,
                   ir_lh: IR_LH, ir_en: IR_Enable, ir_fun: IR_Funsel,
                   wr: Mem_WR, cs: Mem_CS, ma: MuxASel, mb: MuxBSel,
                   mc: MuxCSel, ill: Illegal};

  always #5 Clock = ~Clock;

  // Cycles an instruction occupies, counted from its first fetch cycle.
  function automatic int instr_len(logic [15:0] ir);
    return (ir[15:12] == 4'h1 || ir[15:12] == 4'h2) ? 4 : 3;
  endfunction

  // Expected control word for cycle 'pos' of an instruction (-1 = INIT cycle).
  function automatic outs_t model(int pos, logic [15:0] ir, logic [3:0] fl);
    outs_t o;
    int op;
    logic [3:0] rd_b;
    o = '0;
    o.rf_reg = 4'b1111;
    o.arf_reg = 3'b111;
    o.cs = 1'b1;
    op = int'(ir[15:12]);
    rd_b = 4'b1111;
    rd_b[3 - int'(ir[11:10])] = 1'b0;
    if (pos == -1) begin
      o.rf_fun = 2'd3; o.rf_reg = 4'b0000;
      o.arf_fun = 2'd3; o.arf_reg = 3'b000;
    end else if (pos < 2) begin
      o.cs = 1'b0; o.ir_en = 1'b1; o.ir_fun = 2'd2; o.ir_lh = (pos == 1);
      o.arf_fun = 2'd1; o.arf_reg = 3'b011;
    end else if (pos == 2) begin
      if (op == 0) begin
        o.rf_fun = 2'd2; o.rf_reg = rd_b;
      end else if (op == 1 || op == 2) begin
        o.mb = 2'd1; o.arf_fun = 2'd2; o.arf_reg = 3'b101;
      end else if (op == 3) begin
        o.ra = ir[11:10]; o.rb = ir[9:8]; o.mc = 1'b1; o.alu_fun = ir[7:4];
        o.ma = 2'd3; o.rf_fun = 2'd2; o.rf_reg = rd_b;
      end else if (op == 4 || (op == 5 && fl[3])) begin
        o.mb = 2'd1; o.arf_fun = 2'd2; o.arf_reg = 3'b011;
      end else if (op >= 6) begin
        o.ill = 1'b1;
      end
    end else begin
      o.cs = 1'b0; o.ad = 2'd2;
      if (op == 1) begin
        o.ma = 2'd1; o.rf_fun = 2'd2; o.rf_reg = rd_b;
      end else begin
        o.wr = 1'b1; o.ra = ir[11:10]; o.mc = 1'b1;
      end
    end
    return o;
  endfunction

  // Enter with the DUT in FETCH_H just after a falling edge; leaves it the same way.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input string name);
    outs_t exp_o;
    IR_In = ir;
    Flags = fl;
    for (int p = 0; p < instr_len(ir); p++) begin
      #1;
      exp_o = model(p, ir, fl);
      n_cmp++;
      if (dut_o !== exp_o) begin
        n_bad++;
        $display("FAIL %s ir=%h cyc=%0d: got %h expected %h", name, ir, p, dut_o, exp_o);
      end
      @(posedge Clock);
      @(negedge Clock);
    end
  endtask

  task automatic test_reset;
    outs_t exp_o;
    Reset_n = 1'b0;
    IR_In = 16'h2440;
    repeat (2) @(negedge Clock);
    exp_o = model(-1, IR_In, Flags);
    n_cmp++;
    if (dut_o !== exp_o) begin
      n_bad++;
      $display("FAIL reset_hold: got %h expected %h", dut_o, exp_o);
    end
    Reset_n = 1'b1;
    #1;
    n_cmp++;
    if (dut_o !== exp_o) begin
      n_bad++;
      $display("FAIL reset_init_cycle: got %h expected %h", dut_o, exp_o);
    end
    @(posedge Clock);
    @(negedge Clock);
    n_cmp++;
    if (IR_LH !== 1'b0 || ARF_RegSel !== 3'b011 || IR_Enable !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_fetch_h: got lh=%b arf_reg=%b en=%b expected 0 011 1",
               IR_LH, ARF_RegSel, IR_Enable);
    end
  endtask

  task automatic test_ldi;
    run_instr(16'h0C5A, 4'h0, "ldi");
    n_cmp++;
    if (IR_Enable !== 1'b1 || IR_LH !== 1'b0) begin
      n_bad++;
      $display("FAIL ldi_next_fetch: got en=%b lh=%b expected 1 0", IR_Enable, IR_LH);
    end
  endtask

  task automatic test_ldm_st;
    run_instr(16'h1B33, 4'h0, "ldm");
    run_instr(16'h2440, 4'h0, "st");
  endtask

  task automatic test_bz;
    run_instr(16'h5010, 4'b0000, "bz_not_taken");
    run_instr(16'h5010, 4'b1000, "bz_taken");
    run_instr(16'h5010, 4'b0111, "bz_other_flags");
    run_instr(16'h4077, 4'b0000, "bra");
  endtask

  task automatic test_alu;
    run_instr(16'h3640, 4'h0, "alu");
    run_instr(16'h3DF0, 4'h8, "alu_max");
  endtask

  task automatic test_illegal;
    run_instr(16'hF000, 4'h0, "illegal_f");
    n_cmp++;
    if (Illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_one_cycle: got %b expected 0", Illegal);
    end
    run_instr(16'h6123, 4'h8, "illegal_6");
  endtask

  task automatic test_reset_mid_st;
    outs_t exp_o;
    IR_In = 16'h2440;
    Flags = 4'h0;
    repeat (3) begin
      @(posedge Clock);
      @(negedge Clock);
    end
    #1;
    n_cmp++;
    if (Mem_WR !== 1'b1) begin
      n_bad++;
      $display("FAIL st_exec2_wr: got %b expected 1", Mem_WR);
    end
    Reset_n = 1'b0;
    #1;
    exp_o = model(-1, IR_In, Flags);
    n_cmp++;
    if (dut_o !== exp_o) begin
      n_bad++;
      $display("FAIL reset_mid_st: got %h expected %h", dut_o, exp_o);
    end
    @(posedge Clock);
    #1;
    n_cmp++;
    if (Mem_WR !== 1'b0 || dut_o !== exp_o) begin
      n_bad++;
      $display("FAIL reset_mid_st_hold: got %h expected %h", dut_o, exp_o);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_random;
    logic [15:0] ir;
    logic [3:0] fl;
    for (int i = 0; i < 300; i++) begin
      ir = {4'($urandom_range(0, 7)), 12'($urandom)};
      fl = 4'($urandom);
      run_instr(ir, fl, "random");
    end
  endtask

  task automatic test_back_to_back;
    run_instr(16'h2C01, 4'h0, "b2b_st");
    run_instr(16'h1402, 4'h0, "b2b_ldm");
    run_instr(16'h0003, 4'h0, "b2b_ldi");
    run_instr(16'hFFFF, 4'hF, "b2b_illegal");
    run_instr(16'h5000, 4'hF, "b2b_bz");
  endtask

  initial begin
    @(negedge Clock);
    test_reset;
    test_ldi;
    test_ldm_st;
    test_bz;
    test_alu;
    test_illegal;
    test_back_to_back;
    test_reset_mid_st;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
